// File: rtl/multi_dataflow_tile_sched_pkg.sv
// Shared types and constants for the multi_dataflow tile scheduler.
package multi_dataflow_package;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ADVANCE,
        DONE
    } tile_sched_state_t;

    localparam int STREAM_IN1   = 0;
    localparam int STREAM_IN2   = 1;
    localparam int STREAM_OUT_R = 2;

    // Register-file byte offsets of the tiling job fields
    localparam int unsigned REG_NB_TILES          = 32'h20;
    localparam int unsigned REG_IN1_TILE_STRIDE   = 32'h24;
    localparam int unsigned REG_IN2_TILE_STRIDE   = 32'h28;
    localparam int unsigned REG_OUT_R_TILE_STRIDE = 32'h2C;

endpackage

// File: rtl/multi_dataflow_tile_addr_gen.sv
// One stream's tile base-address register: loaded at job start, advanced by
// the latched stride between tiles (silent modulo-2^ADDR_WIDTH wrap).
module multi_dataflow_tile_addr_gen #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  adv_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [ADDR_WIDTH-1:0] stride_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_o   <= '0;
            stride_q <= '0;
        end else if (clear_i) begin
            addr_o   <= '0;
            stride_q <= '0;
        end else if (load_i) begin
            addr_o   <= base_i;
            stride_q <= stride_i;
        end else if (adv_i) begin
            addr_o   <= addr_o + stride_q;
        end
    end

endmodule

// File: rtl/multi_dataflow_tile_sched.sv
// Tile scheduler: replays one kernel job over nb_tiles tiles, handshaking each
// tile with the datapath FSM. Optional perf counters: MULTI_DATAFLOW_TILE_SCHED_PERF_EN.
module multi_dataflow_tile_sched
    import multi_dataflow_package::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int N_STREAMS  = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic                                 start_i,
    input  logic [CNT_WIDTH-1:0]                 cfg_nb_tiles_i,
    input  logic [N_STREAMS-1:0][ADDR_WIDTH-1:0] cfg_base_addr_i,
    input  logic [N_STREAMS-1:0][ADDR_WIDTH-1:0] cfg_tile_stride_i,
    output logic                                 tile_start_o,
    input  logic                                 tile_ready_i,
    input  logic                                 tile_done_i,
    output logic [N_STREAMS-1:0][ADDR_WIDTH-1:0] tile_addr_o,
    output logic [CNT_WIDTH-1:0]                 tile_idx_o,
    output logic                                 busy_o,
    output logic                                 done_o
`ifdef MULTI_DATAFLOW_TILE_SCHED_PERF_EN
    ,
    output logic [31:0]                          perf_cycles_o,
    output logic [31:0]                          perf_stall_o
`endif
);

    tile_sched_state_t    state_q, state_d;
    logic [CNT_WIDTH-1:0] nb_tiles_q;
    logic                 load, adv, last_tile;

    assign load      = (state_q == IDLE) && start_i;
    assign adv       = (state_q == ADVANCE);
    // Only compared in WAIT, where nb_tiles_q >= 1, so the decrement cannot wrap
    assign last_tile = (tile_idx_o == nb_tiles_q - CNT_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (cfg_nb_tiles_i == '0) ? DONE : ISSUE;
            ISSUE:   if (tile_ready_i) state_d = WAIT;
            WAIT:    if (tile_done_i) state_d = last_tile ? DONE : ADVANCE;
            ADVANCE: state_d = ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            nb_tiles_q <= '0;
            tile_idx_o <= '0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            nb_tiles_q <= '0;
            tile_idx_o <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                nb_tiles_q <= cfg_nb_tiles_i;
                tile_idx_o <= '0;
            end else if (adv) begin
                tile_idx_o <= tile_idx_o + CNT_WIDTH'(1);
            end
        end
    end

    assign tile_start_o = (state_q == ISSUE);
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);

    for (genvar s = 0; s < N_STREAMS; s++) begin : g_stream
        multi_dataflow_tile_addr_gen #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_addr_gen (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clear_i  (clear_i),
            .load_i   (load),
            .adv_i    (adv),
            .base_i   (cfg_base_addr_i[s]),
            .stride_i (cfg_tile_stride_i[s]),
            .addr_o   (tile_addr_o[s])
        );
    end

`ifdef MULTI_DATAFLOW_TILE_SCHED_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cycles_o <= '0;
            perf_stall_o  <= '0;
        end else if (clear_i || load) begin
            perf_cycles_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (busy_o && (perf_cycles_o != '1))
                perf_cycles_o <= perf_cycles_o + 32'd1;
            if (tile_start_o && !tile_ready_i && (perf_stall_o != '1))
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
